aux_reply_decoder: RTL and testbench

- Receives the raw AUX reply byte stream from the AUX PHY receiver and decodes the reply header into the native reply command (ACK/NACK/DEFER) and the I2C reply command.
- Buffers the reply data bytes and re-issues them as one gap-free burst, which is what the AUX control unit requires: ack strobe in one cycle, data on every following cycle until done.
- Sits between the PHY RX deserializer (upstream) and the AUX control unit and the I2C-over-AUX FSM (downstream).

---
 rtl/aux_pkg.sv | 30 +++
 rtl/aux_reply_buf.sv | 47 ++++
 rtl/aux_reply_decoder.sv | 169 ++++++++++++++++
 tb/tb_aux_reply_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_pkg.sv
// Shared types and constants for the AUX reply path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package aux_pkg;

  // Default sizing: AUX replies carry at most 16 data bytes after the header.
  localparam int MAX_DATA_DEF = 16;
  localparam int CNT_W_DEF    = 5;

  // Native reply codes, header[5:4].
  localparam logic [1:0] RPL_ACK   = 2'b00;
  localparam logic [1:0] RPL_NACK  = 2'b01;
  localparam logic [1:0] RPL_DEFER = 2'b10;
  localparam logic [1:0] RPL_RSVD  = 2'b11;

  // I2C-over-AUX reply codes, header[7:6].
  localparam logic [1:0] I2C_ACK   = 2'b00;
  localparam logic [1:0] I2C_NACK  = 2'b01;
  localparam logic [1:0] I2C_DEFER = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_DROP,
    ST_ERR,
    ST_ACK,
    ST_BURST
  } state_t;

endpackage

// File: rtl/aux_reply_buf.sv
// Reply data buffer: MAX_DATA x 8 register array with write/read pointers and flush.
// Latency: write visible on read port the cycle after wr_en; rd_dat is mem[rd_ptr] combinationally.
// Backpressure: none; the caller never writes past MAX_DATA or reads past count-1.
// Ports: clk, rst_n; flush clears both pointers; wr_en/wr_dat append at count;
//        rd_en advances rd_ptr; count, rd_ptr and rd_dat are exported.
module aux_reply_buf #(
  parameter int MAX_DATA = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [7:0]       wr_dat,
  input  logic             rd_en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] rd_ptr,
  output logic [7:0]       rd_dat
);

  localparam int AW = $clog2(MAX_DATA);

  logic [7:0] mem [MAX_DATA];

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[count[AW-1:0]] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) count  <= count + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/aux_reply_decoder.sv
// AUX reply decoder: decodes the reply header and replays buffered data as one gap-free burst.
// Latency: end byte sampled at edge T -> ack strobe in cycle T+1, data byte k in cycle T+2+k.
// Backpressure: none; downstream must accept the burst, upstream bytes during ACK/BURST are dropped with reply_err.
// Ports: clk, rst_n; phy_rx_byte/_vld/phy_rx_end from the PHY deserializer;
//        ctrl_tr_vld/ctrl_i2c_native from the control unit (abort + mode);
//        reply_ack(_vld), i2c_reply_ack(_vld), reply_data(_vld), reply_err to the consumers.
module aux_reply_decoder
  import aux_pkg::*;
#(
  parameter int MAX_DATA = MAX_DATA_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] phy_rx_byte,
  input  logic       phy_rx_byte_vld,
  input  logic       phy_rx_end,
  input  logic       ctrl_tr_vld,
  input  logic       ctrl_i2c_native,
  output logic [1:0] reply_ack,
  output logic       reply_ack_vld,
  output logic [1:0] i2c_reply_ack,
  output logic       i2c_reply_ack_vld,
  output logic [7:0] reply_data,
  output logic       reply_data_vld,
  output logic       reply_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA);

  state_t           state;
  logic [3:0]       hdr_q;     // header[7:4]: {i2c code, native code}
  logic             mode_i2c;
  logic             buf_flush;
  logic             buf_wr;
  logic             buf_rd;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] rd_ptr;
  logic [7:0]       rd_dat;
  logic             last_rd;

  // Final byte of the burst is being presented this cycle.
  assign last_rd = (rd_ptr == count - 1'b1);

  // A new header resets the pointers so the previous reply never leaks into this one.
  assign buf_flush = ctrl_tr_vld || (state == ST_IDLE && phy_rx_byte_vld);
  assign buf_wr    = !ctrl_tr_vld && state == ST_RECV && phy_rx_byte_vld && count != MAX_CNT;
  // The read pointer stays on the last byte rather than stepping past the valid range.
  assign buf_rd    = !ctrl_tr_vld &&
                     ((state == ST_ACK && count > 1) || (state == ST_BURST && !last_rd));

  aux_reply_buf #(
    .MAX_DATA (MAX_DATA),
    .CNT_W    (CNT_W)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (buf_flush),
    .wr_en  (buf_wr),
    .wr_dat (phy_rx_byte),
    .rd_en  (buf_rd),
    .count  (count),
    .rd_ptr (rd_ptr),
    .rd_dat (rd_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      hdr_q             <= '0;
      mode_i2c          <= 1'b0;
      reply_ack         <= '0;
      reply_ack_vld     <= 1'b0;
      i2c_reply_ack     <= '0;
      i2c_reply_ack_vld <= 1'b0;
      reply_data        <= '0;
      reply_data_vld    <= 1'b0;
      reply_err         <= 1'b0;
    end else begin
      // Strobes and data default low; reply_ack/i2c_reply_ack hold.
      reply_ack_vld     <= 1'b0;
      i2c_reply_ack_vld <= 1'b0;
      reply_data        <= '0;
      reply_data_vld    <= 1'b0;
      reply_err         <= 1'b0;

      if (ctrl_tr_vld) begin
        mode_i2c <= ctrl_i2c_native;
        state    <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (phy_rx_byte_vld) begin
              hdr_q <= phy_rx_byte[7:4];
              if (!phy_rx_end) begin
                state <= ST_RECV;
              end else if (phy_rx_byte[5:4] == RPL_RSVD) begin
                state     <= ST_ERR;
                reply_err <= 1'b1;
              end else begin
                state             <= ST_ACK;
                reply_ack         <= phy_rx_byte[5:4];
                reply_ack_vld     <= 1'b1;
                i2c_reply_ack     <= phy_rx_byte[7:6];
                i2c_reply_ack_vld <= mode_i2c;
              end
            end
          end

          ST_RECV: begin
            if (phy_rx_byte_vld) begin
              if (count == MAX_CNT) begin
                if (phy_rx_end) begin
                  state     <= ST_ERR;
                  reply_err <= 1'b1;
                end else begin
                  state <= ST_DROP;
                end
              end else if (phy_rx_end) begin
                if (hdr_q[1:0] == RPL_RSVD) begin
                  state     <= ST_ERR;
                  reply_err <= 1'b1;
                end else begin
                  state             <= ST_ACK;
                  reply_ack         <= hdr_q[1:0];
                  reply_ack_vld     <= 1'b1;
                  i2c_reply_ack     <= hdr_q[3:2];
                  i2c_reply_ack_vld <= mode_i2c;
                end
              end
            end
          end

          ST_DROP: begin
            if (phy_rx_byte_vld && phy_rx_end) begin
              state     <= ST_ERR;
              reply_err <= 1'b1;
            end
          end

          ST_ERR: begin
            state <= ST_IDLE;
          end

          ST_ACK: begin
            reply_err <= phy_rx_byte_vld;
            if (count != '0) begin
              reply_data     <= rd_dat;
              reply_data_vld <= 1'b1;
              state          <= (count == 1) ? ST_IDLE : ST_BURST;
            end else begin
              state <= ST_IDLE;
            end
          end

          ST_BURST: begin
            reply_err      <= phy_rx_byte_vld;
            reply_data     <= rd_dat;
            reply_data_vld <= 1'b1;
            if (last_rd) state <= ST_IDLE;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aux_reply_decoder.sv
// Directed bench for aux_reply_decoder with hand-computed expectations.
// Latency: checks are taken 1 ns after each rising edge.
// Backpressure: n/a.
module tb_aux_reply_decoder;
  import aux_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] phy_rx_byte = '0;
  logic       phy_rx_byte_vld = 1'b0;
  logic       phy_rx_end = 1'b0;
  logic       ctrl_tr_vld = 1'b0;
  logic       ctrl_i2c_native = 1'b0;
  logic [1:0] reply_ack;
  logic       reply_ack_vld;
  logic [1:0] i2c_reply_ack;
  logic       i2c_reply_ack_vld;
  logic [7:0] reply_data;
  logic       reply_data_vld;
  logic       reply_err;

  int n_cmp = 0;
  int n_bad = 0;

  aux_reply_decoder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .phy_rx_byte       (phy_rx_byte),
    .phy_rx_byte_vld   (phy_rx_byte_vld),
    .phy_rx_end        (phy_rx_end),
    .ctrl_tr_vld       (ctrl_tr_vld),
    .ctrl_i2c_native   (ctrl_i2c_native),
    .reply_ack         (reply_ack),
    .reply_ack_vld     (reply_ack_vld),
    .i2c_reply_ack     (i2c_reply_ack),
    .i2c_reply_ack_vld (i2c_reply_ack_vld),
    .reply_data        (reply_data),
    .reply_data_vld    (reply_data_vld),
    .reply_err         (reply_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one edge; returns 1 ns after that edge.
  task automatic send(input logic [7:0] b, input logic e);
    phy_rx_byte     = b;
    phy_rx_byte_vld = 1'b1;
    phy_rx_end      = e;
    tick();
    phy_rx_byte     = '0;
    phy_rx_byte_vld = 1'b0;
    phy_rx_end      = 1'b0;
  endtask

  task automatic ctrl_req(input logic i2c);
    ctrl_tr_vld     = 1'b1;
    ctrl_i2c_native = i2c;
    tick();
    ctrl_tr_vld     = 1'b0;
    ctrl_i2c_native = 1'b0;
  endtask

  initial begin
    logic [7:0] v;

    // Reset values
    #2;
    chk("rst_ack_vld",  {7'd0, reply_ack_vld}, 8'h00);
    chk("rst_ack",      {6'd0, reply_ack}, 8'h00);
    chk("rst_i2c_ack",  {6'd0, i2c_reply_ack}, 8'h00);
    chk("rst_data_vld", {7'd0, reply_data_vld}, 8'h00);
    chk("rst_data",     reply_data, 8'h00);
    chk("rst_err",      {7'd0, reply_err}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Native read ACK: header 0x00, data A1..A4 with idle gaps
    send(8'h00, 1'b0); tick();
    send(8'hA1, 1'b0); tick();
    send(8'hA2, 1'b0); tick();
    send(8'hA3, 1'b0); tick();
    send(8'hA4, 1'b1);
    chk("rd_ack_vld",  {7'd0, reply_ack_vld}, 8'h01);
    chk("rd_ack",      {6'd0, reply_ack}, {6'd0, RPL_ACK});
    chk("rd_i2c_vld",  {7'd0, i2c_reply_ack_vld}, 8'h00);
    chk("rd_dvld_ack", {7'd0, reply_data_vld}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      v = 8'hA1 + 8'(k);
      chk("rd_dvld", {7'd0, reply_data_vld}, 8'h01);
      chk("rd_data", reply_data, v);
      chk("rd_ackvld_lo", {7'd0, reply_ack_vld}, 8'h00);
    end
    tick();
    chk("rd_dvld_end", {7'd0, reply_data_vld}, 8'h00);
    chk("rd_data_end", reply_data, 8'h00);
    chk("rd_ack_hold", {6'd0, reply_ack}, 8'h00);

    // Native write NACK: header 0x10, one byte 0x03
    send(8'h10, 1'b0);
    send(8'h03, 1'b1);
    chk("nack_vld", {7'd0, reply_ack_vld}, 8'h01);
    chk("nack_ack", {6'd0, reply_ack}, {6'd0, RPL_NACK});
    tick();
    chk("nack_dvld", {7'd0, reply_data_vld}, 8'h01);
    chk("nack_data", reply_data, 8'h03);
    tick();
    chk("nack_dvld_end", {7'd0, reply_data_vld}, 8'h00);
    chk("nack_ack_hold", {6'd0, reply_ack}, {6'd0, RPL_NACK});

    // DEFER, header only
    send(8'h20, 1'b1);
    chk("defer_vld", {7'd0, reply_ack_vld}, 8'h01);
    chk("defer_ack", {6'd0, reply_ack}, {6'd0, RPL_DEFER});
    tick();
    chk("defer_dvld0", {7'd0, reply_data_vld}, 8'h00);
    tick();
    chk("defer_dvld1", {7'd0, reply_data_vld}, 8'h00);

    // I2C mode: header 0x40
    ctrl_req(1'b1);
    send(8'h40, 1'b1);
    chk("i2c_ack_vld", {7'd0, reply_ack_vld}, 8'h01);
    chk("i2c_i2c_vld", {7'd0, i2c_reply_ack_vld}, 8'h01);
    chk("i2c_ack",     {6'd0, reply_ack}, {6'd0, RPL_ACK});
    chk("i2c_code",    {6'd0, i2c_reply_ack}, {6'd0, I2C_NACK});
    tick();
    chk("i2c_vld_lo",  {7'd0, i2c_reply_ack_vld}, 8'h00);
    chk("i2c_code_hold", {6'd0, i2c_reply_ack}, {6'd0, I2C_NACK});
    ctrl_req(1'b0);
    chk("abort_idle_err", {7'd0, reply_err}, 8'h00);

    // Overflow: header + 17 data bytes, end on the 17th
    send(8'h00, 1'b0);
    for (int k = 0; k < 16; k++) send(8'(k), 1'b0);
    send(8'h99, 1'b1);
    chk("ovf_err",     {7'd0, reply_err}, 8'h01);
    chk("ovf_ack_vld", {7'd0, reply_ack_vld}, 8'h00);
    tick();
    chk("ovf_err_lo",  {7'd0, reply_err}, 8'h00);
    chk("ovf_dvld",    {7'd0, reply_data_vld}, 8'h00);

    // Overflow through the drop path: header + 18 data bytes
    send(8'h00, 1'b0);
    for (int k = 0; k < 17; k++) send(8'(k), 1'b0);
    chk("drop_err_mid", {7'd0, reply_err}, 8'h00);
    send(8'h98, 1'b1);
    chk("drop_err",     {7'd0, reply_err}, 8'h01);
    chk("drop_ack_vld", {7'd0, reply_ack_vld}, 8'h00);
    tick();
    chk("drop_err_lo",  {7'd0, reply_err}, 8'h00);

    // Exactly 16 data bytes is legal
    send(8'h00, 1'b0);
    for (int k = 0; k < 15; k++) send(8'h60 + 8'(k), 1'b0);
    send(8'h6F, 1'b1);
    chk("full_ack_vld", {7'd0, reply_ack_vld}, 8'h01);
    for (int k = 0; k < 16; k++) begin
      tick();
      v = 8'h60 + 8'(k);
      chk("full_data", reply_data, v);
    end
    tick();
    chk("full_dvld_end", {7'd0, reply_data_vld}, 8'h00);

    // Reserved native code
    send(8'h30, 1'b1);
    chk("rsvd_err",     {7'd0, reply_err}, 8'h01);
    chk("rsvd_ack_vld", {7'd0, reply_ack_vld}, 8'h00);
    tick();
    chk("rsvd_err_lo",  {7'd0, reply_err}, 8'h00);

    // Abort mid-RECV, then a fresh reply
    send(8'h00, 1'b0);
    send(8'h11, 1'b0);
    ctrl_req(1'b0);
    chk("abort_err",  {7'd0, reply_err}, 8'h00);
    chk("abort_vld",  {7'd0, reply_ack_vld}, 8'h00);
    send(8'h00, 1'b0);
    send(8'h5A, 1'b1);
    chk("abort_new_vld", {7'd0, reply_ack_vld}, 8'h01);
    chk("abort_new_err", {7'd0, reply_err}, 8'h00);
    tick();
    chk("abort_new_data", reply_data, 8'h5A);
    chk("abort_new_dvld", {7'd0, reply_data_vld}, 8'h01);
    tick();
    chk("abort_new_end",  {7'd0, reply_data_vld}, 8'h00);
    chk("abort_new_err2", {7'd0, reply_err}, 8'h00);

    // Stray byte during ACK: burst unaffected, one error pulse
    send(8'h00, 1'b0);
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b1);
    chk("stray_ack_vld", {7'd0, reply_ack_vld}, 8'h01);
    send(8'hEE, 1'b0);
    chk("stray_err",   {7'd0, reply_err}, 8'h01);
    chk("stray_data0", reply_data, 8'hB1);
    tick();
    chk("stray_err_lo", {7'd0, reply_err}, 8'h00);
    chk("stray_data1",  reply_data, 8'hB2);
    tick();
    chk("stray_dvld_end", {7'd0, reply_data_vld}, 8'h00);

    // Reset mid-burst, then a clean reply
    send(8'h10, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b1);
    tick();
    chk("mrst_pre", reply_data, 8'hC1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_dvld", {7'd0, reply_data_vld}, 8'h00);
    chk("mrst_ack",  {6'd0, reply_ack}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(8'h00, 1'b0);
    send(8'h77, 1'b1);
    tick();
    chk("mrst_new_data", reply_data, 8'h77);
    tick();
    chk("mrst_new_end", {7'd0, reply_data_vld}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
